// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Shared FSM state encoding and constants for the hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  localparam int         REG_IDX_W     = 5;
  localparam int         WAIT_CNT_W    = 8;
  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_BR_FLUSH   = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// ============================================================================
// Module   : hazard_cmp
// Brief    : Combinational load-use comparator: three ID sources against rd_ex.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_cmp
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic [REG_IDX_W-1:0] rs3_id,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic                 mem_read_ex,
  input  logic                 reg_write_ex,
  output logic                 hazard
);

  logic w_src_match;
  logic w_rd_valid;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_rd_valid  = mem_read_ex && reg_write_ex && (rd_ex != '0);
  assign w_src_match = (rd_ex == rs1_id) || (rd_ex == rs2_id) || (rd_ex == rs3_id);
  assign hazard      = w_rd_valid && w_src_match;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Moore hazard FSM (load-use stall, branch flush, vector-memory wait).
//            Optional HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic [REG_IDX_W-1:0] rs3_id,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic                 mem_read_ex,
  input  logic                 reg_write_ex,
  input  logic                 branch_taken_ex,
  input  logic                 vmem_req_ex,
  input  logic                 vmem_done,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 idex_stall,
  output logic                 exmem_stall,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 busy,
  output logic                 timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]          stall_cnt,
  output logic [15:0]          flush_cnt
`endif
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_inc;
  logic                  w_timeout_set;
  logic                  w_hazard;

  logic r_pc_stall, r_ifid_stall, r_idex_stall, r_exmem_stall;
  logic r_ifid_flush, r_idex_flush, r_busy, r_timeout_err;
  logic w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall;
  logic w_ifid_flush, w_idex_flush, w_busy;

  hazard_cmp u_hazard_cmp (
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs3_id       (rs3_id),
    .rd_ex        (rd_ex),
    .mem_read_ex  (mem_read_ex),
    .reg_write_ex (reg_write_ex),
    .hazard       (w_hazard)
  );

  assign w_wait_cnt_inc = r_wait_cnt + 8'd1;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_set  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_wait_cnt_nxt = '0;
        if (vmem_req_ex)          w_state_nxt = ST_MEM_WAIT;
        else if (branch_taken_ex) w_state_nxt = ST_BR_FLUSH;
        else if (w_hazard)        w_state_nxt = ST_LOAD_STALL;
      end
      ST_LOAD_STALL: w_state_nxt = ST_RUN;
      ST_BR_FLUSH:   w_state_nxt = ST_RUN;
      ST_MEM_WAIT: begin
        // Completion wins over a timeout landing on the same cycle
        if (vmem_done) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (w_wait_cnt_inc == TIMEOUT_LIMIT) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
          w_timeout_set  = 1'b1;
        end else begin
          w_wait_cnt_nxt = w_wait_cnt_inc;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it
  always_comb begin
    w_pc_stall    = 1'b0;
    w_ifid_stall  = 1'b0;
    w_idex_stall  = 1'b0;
    w_exmem_stall = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_busy        = (w_state_nxt != ST_RUN);
    case (w_state_nxt)
      ST_LOAD_STALL: begin
        w_pc_stall   = 1'b1;
        w_ifid_stall = 1'b1;
        w_idex_flush = 1'b1;
      end
      ST_BR_FLUSH: begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end
      ST_MEM_WAIT: begin
        w_pc_stall    = 1'b1;
        w_ifid_stall  = 1'b1;
        w_idex_stall  = 1'b1;
        w_exmem_stall = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_pc_stall    <= 1'b0;
      r_ifid_stall  <= 1'b0;
      r_idex_stall  <= 1'b0;
      r_exmem_stall <= 1'b0;
      r_ifid_flush  <= 1'b0;
      r_idex_flush  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_pc_stall    <= w_pc_stall;
      r_ifid_stall  <= w_ifid_stall;
      r_idex_stall  <= w_idex_stall;
      r_exmem_stall <= w_exmem_stall;
      r_ifid_flush  <= w_ifid_flush;
      r_idex_flush  <= w_idex_flush;
      r_busy        <= w_busy;
      r_timeout_err <= r_timeout_err | w_timeout_set;
    end
  end

  assign pc_stall    = r_pc_stall;
  assign ifid_stall  = r_ifid_stall;
  assign idex_stall  = r_idex_stall;
  assign exmem_stall = r_exmem_stall;
  assign ifid_flush  = r_ifid_flush;
  assign idex_flush  = r_idex_flush;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(negedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_pc_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (r_idex_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rs3_id, rd_ex;
  logic       mem_read_ex, reg_write_ex, branch_taken_ex, vmem_req_ex, vmem_done;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_flush, idex_flush, busy, timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, busy, timeout_err}
  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LOAD = 8'b1100_0110;
  localparam logic [7:0] O_BR   = 8'b0000_1110;
  localparam logic [7:0] O_MEM  = 8'b1111_0010;
  localparam logic [7:0] O_TO   = 8'b0000_0001;

  logic [7:0] w_outs;
  assign w_outs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                   ifid_flush, idex_flush, busy, timeout_err};

  pipeline_hazard_ctrl u_dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs3_id          (rs3_id),
    .rd_ex           (rd_ex),
    .mem_read_ex     (mem_read_ex),
    .reg_write_ex    (reg_write_ex),
    .branch_taken_ex (branch_taken_ex),
    .vmem_req_ex     (vmem_req_ex),
    .vmem_done       (vmem_done),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_stall      (idex_stall),
    .exmem_stall     (exmem_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .busy            (busy),
    .timeout_err     (timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance across one active (falling) edge and park on the rising edge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic clear_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rs3_id = 5'd0; rd_ex = 5'd0;
    mem_read_ex = 1'b0; reg_write_ex = 1'b0; branch_taken_ex = 1'b0;
    vmem_req_ex = 1'b0; vmem_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Enter MEM_WAIT and sit through the first 254 wait cycles
  task automatic mem_wait_254();
    vmem_req_ex = 1'b1;
    tick();
    vmem_req_ex = 1'b0;
    for (int i = 0; i < 254; i++) tick();
  endtask

  initial begin
    clear_inputs();
    do_reset();
    check("reset_outs", {24'd0, w_outs}, {24'd0, O_IDLE});
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    tick();
    check("idle_run", {24'd0, w_outs}, {24'd0, O_IDLE});

    // Load-use on rs2
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5;
    tick();
    check("load_use_rs2", {24'd0, w_outs}, {24'd0, O_LOAD});
    clear_inputs();
    tick();
    check("load_use_back_run", {24'd0, w_outs}, {24'd0, O_IDLE});
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_1", {16'd0, stall_cnt}, 32'd1);
    check("perf_flush_1", {16'd0, flush_cnt}, 32'd1);
`endif

    // Load-use on rs3
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd9; rs3_id = 5'd9;
    tick();
    check("load_use_rs3", {24'd0, w_outs}, {24'd0, O_LOAD});
    clear_inputs();
    tick();

    // No write-back: no dependency
    mem_read_ex = 1'b1; reg_write_ex = 1'b0; rd_ex = 5'd7; rs1_id = 5'd7;
    tick();
    check("no_regwrite", {24'd0, w_outs}, {24'd0, O_IDLE});
    clear_inputs();

    // r0 exclusion
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
    tick();
    check("r0_exclusion", {24'd0, w_outs}, {24'd0, O_IDLE});
    clear_inputs();

    // Taken branch
    branch_taken_ex = 1'b1;
    tick();
    check("branch_flush", {24'd0, w_outs}, {24'd0, O_BR});
    branch_taken_ex = 1'b0;
    tick();
    check("branch_back_run", {24'd0, w_outs}, {24'd0, O_IDLE});

    // Stray completion in RUN
    vmem_done = 1'b1;
    tick();
    check("done_outside_wait", {24'd0, w_outs}, {24'd0, O_IDLE});
    vmem_done = 1'b0;

    // Priority: memory beats branch beats hazard; branch replays after exit
    vmem_req_ex = 1'b1; branch_taken_ex = 1'b1;
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3;
    tick();
    check("prio_mem_wait", {24'd0, w_outs}, {24'd0, O_MEM});
    tick();
    tick();
    tick();
    check("prio_still_wait", {24'd0, w_outs}, {24'd0, O_MEM});
    vmem_done = 1'b1; vmem_req_ex = 1'b0;
    tick();
    check("prio_done_run", {24'd0, w_outs}, {24'd0, O_IDLE});
    vmem_done = 1'b0;
    tick();
    check("prio_branch_after", {24'd0, w_outs}, {24'd0, O_BR});
    clear_inputs();
    tick();

    // Timeout after 255 wait cycles
    mem_wait_254();
    check("timeout_pre", {24'd0, w_outs}, {24'd0, O_MEM});
    tick();
    check("timeout_hit", {24'd0, w_outs}, {24'd0, O_TO});
    branch_taken_ex = 1'b1;
    tick();
    check("timeout_sticky", {24'd0, w_outs}, {24'd0, O_BR | O_TO});
    branch_taken_ex = 1'b0;
    do_reset();
    check("timeout_reset_clr", {24'd0, w_outs}, {24'd0, O_IDLE});

    // Completion on the limit cycle is not a timeout
    mem_wait_254();
    vmem_done = 1'b1;
    tick();
    check("done_at_limit", {24'd0, w_outs}, {24'd0, O_IDLE});
    vmem_done = 1'b0;

    // Reset during the third MEM_WAIT cycle
    vmem_req_ex = 1'b1;
    tick();
    vmem_req_ex = 1'b0;
    tick();
    tick();
    check("mw_before_rst", {24'd0, w_outs}, {24'd0, O_MEM});
    rst = 1'b0;
    tick();
    check("mw_rst_abort", {24'd0, w_outs}, {24'd0, O_IDLE});
`ifdef HAZARD_PERF_CNT_EN
    check("mw_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    rst = 1'b1;
    tick();
    check("mw_rst_no_residual", {24'd0, w_outs}, {24'd0, O_IDLE});

    // Reset during LOAD_STALL
    mem_read_ex = 1'b1; reg_write_ex = 1'b1; rd_ex = 5'd12; rs1_id = 5'd12;
    tick();
    check("ls_before_rst", {24'd0, w_outs}, {24'd0, O_LOAD});
    clear_inputs();
    rst = 1'b0;
    tick();
    check("ls_rst_abort", {24'd0, w_outs}, {24'd0, O_IDLE});
    rst = 1'b1;
    tick();
    check("ls_rst_no_residual", {24'd0, w_outs}, {24'd0, O_IDLE});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
